muldiv_sequencer: RTL and testbench

Controller that sequences the execute stage's multiply and divide units for RV32M complex ops. It accepts one request at a time, latches the operands, drives the pipelined multiplier and divider, and counts their fixed latencies. It resolves divide-by-zero and signed-overflow in one cycle, and serves a DIV/REM pair on the same operands from a one-entry cache. It sits between the execute stage's complex-op path and the multiply and divide units.

---
 rtl/muldiv_sequencer_pkg.sv | 42 ++++
 rtl/muldiv_div_cache.sv | 52 +++++
 rtl/muldiv_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Op encoding matches the 3-bit funct3 of the M extension.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } muldiv_state_t;

  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN           = 32'h8000_0000;

  function automatic logic is_div_op(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  // MULHSU uses the signed multiplier and corrects the high word afterwards
  function automatic logic is_mul_signed(input muldiv_op_t op);
    return ~op[2] & (op != MULHU);
  endfunction

  function automatic logic is_div_signed(input muldiv_op_t op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_div_cache.sv
// One-entry divide result cache: remembers the last full divide so the
// matching DIV/REM of a pair can complete without rerunning the divider.
module muldiv_div_cache
  import muldiv_sequencer_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        wr_en,
  input  logic [31:0] wr_rs1,
  input  logic [31:0] wr_rs2,
  input  logic        wr_signed,
  input  logic [31:0] wr_quotient,
  input  logic [31:0] wr_remainder,
  input  logic [31:0] rd_rs1,
  input  logic [31:0] rd_rs2,
  input  logic        rd_signed,
  output logic        hit,
  output logic [31:0] hit_quotient,
  output logic [31:0] hit_remainder
);

  logic        valid_reg;
  logic [31:0] rs1_reg;
  logic [31:0] rs2_reg;
  logic        signed_reg;
  logic [31:0] quotient_reg;
  logic [31:0] remainder_reg;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      valid_reg     <= 1'b0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      signed_reg    <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else if (wr_en) begin
      valid_reg     <= 1'b1;
      rs1_reg       <= wr_rs1;
      rs2_reg       <= wr_rs2;
      signed_reg    <= wr_signed;
      quotient_reg  <= wr_quotient;
      remainder_reg <= wr_remainder;
    end
  end

  assign hit = valid_reg && (rs1_reg == rd_rs1) && (rs2_reg == rd_rs2)
               && (signed_reg == rd_signed);
  assign hit_quotient  = quotient_reg;
  assign hit_remainder = remainder_reg;

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the external pipelined multiplier and divider for RV32M ops,
// short-circuiting divide special cases and repeated-operand DIV/REM pairs.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 34
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic [31:0] o_mul_op1,
  output logic [31:0] o_mul_op2,
  output logic        o_mul_signed,
  input  logic [63:0] i_mul_result,
  output logic [31:0] o_div_numerator,
  output logic [31:0] o_div_denominator,
  output logic        o_div_signed,
  input  logic [31:0] i_div_result,
  input  logic [31:0] i_div_remainder
);

  localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY);

  muldiv_state_t state_reg, state_next;
  muldiv_op_t    op_reg, op_next;
  logic [5:0]    cnt_reg, cnt_next;
  logic [31:0]   result_reg, result_next;
  logic          done_reg, done_next;
  logic [31:0]   mul_op1_reg, mul_op1_next;
  logic [31:0]   mul_op2_reg, mul_op2_next;
  logic          mul_signed_reg, mul_signed_next;
  logic [31:0]   div_num_reg, div_num_next;
  logic [31:0]   div_den_reg, div_den_next;
  logic          div_signed_reg, div_signed_next;

  muldiv_op_t    start_op;
  logic          start_rem;
  logic          start_div_signed;
  logic          cache_wr;
  logic          cache_hit;
  logic [31:0]   cache_quotient;
  logic [31:0]   cache_remainder;
  logic [31:0]   mul_selected;
  logic [31:0]   div_selected;

  assign start_op         = muldiv_op_t'(i_op);
  assign start_rem        = is_rem_op(start_op);
  assign start_div_signed = is_div_signed(start_op);

  muldiv_div_cache u_div_cache (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .wr_en         (cache_wr),
    .wr_rs1        (div_num_reg),
    .wr_rs2        (div_den_reg),
    .wr_signed     (div_signed_reg),
    .wr_quotient   (i_div_result),
    .wr_remainder  (i_div_remainder),
    .rd_rs1        (i_rs1),
    .rd_rs2        (i_rs2),
    .rd_signed     (start_div_signed),
    .hit           (cache_hit),
    .hit_quotient  (cache_quotient),
    .hit_remainder (cache_remainder)
  );

  // Signed x signed high word plus rs1 when rs2 is negative gives signed x unsigned
  always_comb begin
    case (op_reg)
      MULH, MULHU: mul_selected = i_mul_result[63:32];
      MULHSU:      mul_selected = i_mul_result[63:32]
                                  + (mul_op2_reg[31] ? mul_op1_reg : 32'd0);
      default:     mul_selected = i_mul_result[31:0];
    endcase
  end

  assign div_selected = is_rem_op(op_reg) ? i_div_remainder : i_div_result;

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    cnt_next        = cnt_reg;
    result_next     = result_reg;
    done_next       = 1'b0;
    mul_op1_next    = mul_op1_reg;
    mul_op2_next    = mul_op2_reg;
    mul_signed_next = mul_signed_reg;
    div_num_next    = div_num_reg;
    div_den_next    = div_den_reg;
    div_signed_next = div_signed_reg;
    cache_wr        = 1'b0;

    if (i_flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            op_next         = start_op;
            mul_op1_next    = i_rs1;
            mul_op2_next    = i_rs2;
            mul_signed_next = is_mul_signed(start_op);
            div_num_next    = i_rs1;
            div_den_next    = i_rs2;
            div_signed_next = start_div_signed;
            if (!is_div_op(start_op)) begin
              cnt_next   = MUL_CNT;
              state_next = MUL_WAIT;
            end else if (i_rs2 == 32'd0) begin
              result_next = start_rem ? i_rs1 : DIV_ZERO_QUOTIENT;
              done_next   = 1'b1;
            end else if (start_div_signed && (i_rs1 == INT_MIN) && (i_rs2 == 32'hFFFF_FFFF)) begin
              result_next = start_rem ? 32'd0 : INT_MIN;
              done_next   = 1'b1;
            end else if (cache_hit) begin
              result_next = start_rem ? cache_remainder : cache_quotient;
              done_next   = 1'b1;
            end else begin
              cnt_next   = DIV_CNT;
              state_next = DIV_WAIT;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt_reg != 6'd0) begin
            cnt_next = cnt_reg - 6'd1;
          end else begin
            result_next = mul_selected;
            done_next   = 1'b1;
            state_next  = IDLE;
          end
        end
        DIV_WAIT: begin
          if (cnt_reg != 6'd0) begin
            cnt_next = cnt_reg - 6'd1;
          end else begin
            result_next = div_selected;
            done_next   = 1'b1;
            cache_wr    = 1'b1;
            state_next  = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg      <= IDLE;
      op_reg         <= MUL;
      cnt_reg        <= '0;
      result_reg     <= '0;
      done_reg       <= 1'b0;
      mul_op1_reg    <= '0;
      mul_op2_reg    <= '0;
      mul_signed_reg <= 1'b0;
      div_num_reg    <= '0;
      div_den_reg    <= '0;
      div_signed_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      cnt_reg        <= cnt_next;
      result_reg     <= result_next;
      done_reg       <= done_next;
      mul_op1_reg    <= mul_op1_next;
      mul_op2_reg    <= mul_op2_next;
      mul_signed_reg <= mul_signed_next;
      div_num_reg    <= div_num_next;
      div_den_reg    <= div_den_next;
      div_signed_reg <= div_signed_next;
    end
  end

  assign o_busy            = (state_reg != IDLE);
  assign o_done            = done_reg;
  assign o_result          = result_reg;
  assign o_mul_op1         = mul_op1_reg;
  assign o_mul_op2         = mul_op2_reg;
  assign o_mul_signed      = mul_signed_reg;
  assign o_div_numerator   = div_num_reg;
  assign o_div_denominator = div_den_reg;
  assign o_div_signed      = div_signed_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with behavioural multiplier/divider
// models driving the unit inputs; expectations are hand-computed constants.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 34;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic        i_flush = 1'b0;
  logic        o_busy, o_done, o_mul_signed, o_div_signed;
  logic [31:0] o_result, o_mul_op1, o_mul_op2, o_div_numerator, o_div_denominator;
  logic [63:0] i_mul_result;
  logic [31:0] i_div_result, i_div_remainder;

  int checks = 0;
  int errors = 0;
  int dones;
  int first_done;

  muldiv_sequencer #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_mul_op1(o_mul_op1), .o_mul_op2(o_mul_op2), .o_mul_signed(o_mul_signed),
    .i_mul_result(i_mul_result),
    .o_div_numerator(o_div_numerator), .o_div_denominator(o_div_denominator),
    .o_div_signed(o_div_signed),
    .i_div_result(i_div_result), .i_div_remainder(i_div_remainder)
  );

  always #5 i_clock = ~i_clock;

  // Multiplier model: full 64-bit product, signed or unsigned
  always_comb begin
    logic signed [63:0] sa, sb;
    sa = {{32{o_mul_op1[31]}}, o_mul_op1};
    sb = {{32{o_mul_op2[31]}}, o_mul_op2};
    if (o_mul_signed) i_mul_result = sa * sb;
    else              i_mul_result = {32'd0, o_mul_op1} * {32'd0, o_mul_op2};
  end

  // Divider model, guarded against zero divisor and signed overflow
  always_comb begin
    logic signed [31:0] sn, sd;
    sn = o_div_numerator;
    sd = o_div_denominator;
    i_div_result    = 32'hFFFF_FFFF;
    i_div_remainder = o_div_numerator;
    if (o_div_denominator != 32'd0) begin
      if (o_div_signed) begin
        if (o_div_numerator == 32'h8000_0000 && o_div_denominator == 32'hFFFF_FFFF) begin
          i_div_result    = 32'h8000_0000;
          i_div_remainder = 32'd0;
        end else begin
          i_div_result    = sn / sd;
          i_div_remainder = sn % sd;
        end
      end else begin
        i_div_result    = o_div_numerator / o_div_denominator;
        i_div_remainder = o_div_numerator % o_div_denominator;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, check busy each cycle, the o_done cycle, result, and the pulse/hold after
  task automatic do_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_cyc, input logic [31:0] exp_res, input string tag);
    int done_cyc;
    done_cyc = -1;
    @(negedge i_clock);
    i_op = op; i_rs1 = a; i_rs2 = b; i_start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge i_clock);
      if (n == 1) begin
        i_start = 1'b0; i_rs1 = $urandom; i_rs2 = $urandom;
      end
      if (o_done) begin
        done_cyc = n;
        break;
      end
      if (n < exp_cyc) chk({tag, "_busy"}, 64'(o_busy), 64'd1);
    end
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    chk({tag, "_result"}, 64'(o_result), 64'(exp_res));
    chk({tag, "_busy_at_done"}, 64'(o_busy), 64'd0);
    @(negedge i_clock);
    chk({tag, "_pulse"}, 64'(o_done), 64'd0);
    chk({tag, "_hold"}, 64'(o_result), 64'(exp_res));
    $display("op %0d rs1=%h rs2=%h -> result=%h done_cycle=%0d", op, a, b, o_result, done_cyc);
  endtask

  initial begin
    // Reset values
    #3 i_reset = 1'b0;
    #1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_result", 64'(o_result), 64'd0);
    chk("rst_mul_ops", {o_mul_op1, o_mul_op2}, 64'd0);
    chk("rst_div_ops", {o_div_numerator, o_div_denominator}, 64'd0);
    chk("rst_signed", {62'd0, o_mul_signed, o_div_signed}, 64'd0);
    $display("reset check done");
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;

    // Multiplies
    do_op(MUL,    32'd7,         32'hFFFF_FFFD, 2 + MUL_LAT, 32'hFFFF_FFEB, "mul");
    do_op(MULHSU, 32'hFFFF_FFFF, 32'h8000_0000, 2 + MUL_LAT, 32'hFFFF_FFFF, "mulhsu");
    do_op(MULHU,  32'hFFFF_FFFF, 32'h8000_0000, 2 + MUL_LAT, 32'h7FFF_FFFF, "mulhu");
    do_op(MULH,   32'hFFFF_FFFE, 32'd3,         2 + MUL_LAT, 32'hFFFF_FFFF, "mulh");
    do_op(MULHU,  32'hFFFF_FFFE, 32'd3,         2 + MUL_LAT, 32'd2,         "mulhu2");

    // Divide special cases
    do_op(DIV,  32'h1234,      32'd0,         1, 32'hFFFF_FFFF, "div_zero");
    do_op(REM,  32'h1234,      32'd0,         1, 32'h1234,      "rem_zero");
    do_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
    do_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         "rem_ovf");
    do_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 2 + DIV_LAT, 32'd0, "divu_no_ovf");

    // Full divides and cache behaviour
    do_op(DIV,  32'd100, 32'd7, 2 + DIV_LAT, 32'd14, "div_100_7");
    do_op(REM,  32'd100, 32'd7, 1,           32'd2,  "rem_hit");
    do_op(REMU, 32'd100, 32'd7, 2 + DIV_LAT, 32'd2,  "remu_miss");
    do_op(DIV,  32'hFFFF_FF9C, 32'd7, 2 + DIV_LAT, 32'hFFFF_FFF2, "div_neg");
    do_op(REM,  32'hFFFF_FF9C, 32'd7, 1,           32'hFFFF_FFFE, "rem_neg_hit");

    // Flush mid-divide, then a MUL accepted in the cycle after the flush
    @(negedge i_clock);
    i_op = DIV; i_rs1 = 32'd1000; i_rs2 = 32'd10; i_start = 1'b1;
    dones = 0;
    first_done = -1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge i_clock);
      if (n == 1) i_start = 1'b0;
      if (o_done) begin
        dones++;
        if (first_done < 0) first_done = n;
      end
      if (n == 3) begin
        chk("flush_busy_before", 64'(o_busy), 64'd1);
        i_flush = 1'b1;
      end
      if (n == 4) begin
        i_flush = 1'b0;
        chk("flush_busy_after", 64'(o_busy), 64'd0);
        i_op = MUL; i_rs1 = 32'd3; i_rs2 = 32'd5; i_start = 1'b1;
      end
      if (n == 5) i_start = 1'b0;
    end
    chk("flush_done_count", 64'(dones), 64'd1);
    chk("flush_mul_cycle", 64'(first_done), 64'(4 + 2 + MUL_LAT));
    chk("flush_mul_result", 64'(o_result), 64'd15);
    $display("flush: dones=%0d first_done=%0d result=%h", dones, first_done, o_result);

    // Reset in the middle of a divide
    @(negedge i_clock);
    i_op = DIV; i_rs1 = 32'd50; i_rs2 = 32'd3; i_start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge i_clock);
      if (n == 1) i_start = 1'b0;
    end
    chk("mid_busy", 64'(o_busy), 64'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_done", 64'(o_done), 64'd0);
    chk("arst_result", 64'(o_result), 64'd0);
    chk("arst_div_ops", {o_div_numerator, o_div_denominator}, 64'd0);
    chk("arst_signed", {62'd0, o_mul_signed, o_div_signed}, 64'd0);
    $display("async reset: busy=%0d done=%0d result=%h", o_busy, o_done, o_result);
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    do_op(DIV, 32'd50, 32'd3, 2 + DIV_LAT, 32'd16, "post_rst_div");
    do_op(REM, 32'd50, 32'd3, 1,           32'd2,  "post_rst_rem_hit");
    do_op(DIV, 32'd50, 32'd4, 2 + DIV_LAT, 32'd12, "post_rst_div_new");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
